riscv_result_checker: RTL and testbench

Synthesizable self-check block that sits directly downstream of the RISCV_TOP core and consumes its NUM_INST, OUTPUT_PORT and HALT outputs. It holds a loadable table of (retired-instruction count, expected OUTPUT_PORT) pairs and compares each entry against the core as the program runs. It reports pass/fail, the first failing entry, and cycle count, so an instruction-test program can be judged on FPGA or in simulation without a behavioural bench.

---
 rtl/riscv_result_checker.sv | 207 ++++++++++++++++++++
 tb/tb_riscv_result_checker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_result_checker.sv
// riscv_result_checker
// Watches a RISC-V core's retired-instruction count and result port, and
// compares them against a loadable table of (instruction count, expected
// result) pairs. It reports pass/fail, the first failing entry, the value
// seen at the failure and the number of RUN cycles spent.
module riscv_result_checker #(
    parameter int          NUM_TEST  = 22,
    parameter int          AWIDTH    = 5,
    parameter logic [31:0] MAX_CYCLE = 32'd100000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tbl_we,
    input  logic [AWIDTH-1:0] i_tbl_addr,
    input  logic [31:0]       i_tbl_num_inst,
    input  logic [31:0]       i_tbl_ans,
    input  logic              i_start,
    input  logic [31:0]       i_num_inst,
    input  logic [31:0]       i_output_port,
    input  logic              i_halt,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [2:0]        o_fail_code,
    output logic [AWIDTH-1:0] o_fail_idx,
    output logic [31:0]       o_fail_got,
    output logic [31:0]       o_fail_exp,
    output logic [AWIDTH:0]   o_pass_cnt,
    output logic [31:0]       o_cycle_cnt
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] LAST_IDX   = AWIDTH'(NUM_TEST - 1);
    // With a single entry there is nothing to order-check; the scan then
    // just spends one cycle on index 0 before moving on.
    localparam logic [AWIDTH-1:0] SCAN_FIRST = (NUM_TEST > 1) ? AWIDTH'(1) : '0;

    localparam logic [2:0] FC_NONE       = 3'd0;
    localparam logic [2:0] FC_MISMATCH   = 3'd1;
    localparam logic [2:0] FC_SKIPPED    = 3'd2;
    localparam logic [2:0] FC_TIMEOUT    = 3'd3;
    localparam logic [2:0] FC_ORDER      = 3'd4;
    localparam logic [2:0] FC_INCOMPLETE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK_TBL,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t r_state;

    // Expected-result table; contents are not reset and must be reloaded.
    logic [31:0] r_tbl_num [DEPTH];
    logic [31:0] r_tbl_ans [DEPTH];

    logic [AWIDTH-1:0] r_ptr;    // next unchecked entry during RUN
    logic [AWIDTH-1:0] r_scan;   // entry being order-checked in CHK_TBL

    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [2:0]        r_fail_code;
    logic [AWIDTH-1:0] r_fail_idx;
    logic [31:0]       r_fail_got;
    logic [31:0]       r_fail_exp;
    logic [AWIDTH:0]   r_pass_cnt;
    logic [31:0]       r_cycle_cnt;

    logic              w_idle_like;
    logic              w_tbl_wr;
    logic [AWIDTH-1:0] w_scan_prev_idx;
    logic [31:0]       w_scan_cur;
    logic [31:0]       w_scan_prev;
    logic [31:0]       w_cur_num;
    logic [31:0]       w_cur_ans;
    logic              w_at;
    logic              w_last;
    logic [2:0]        w_run_code;
    logic              w_run_adv;

    assign w_idle_like     = (r_state == S_IDLE) || (r_state == S_PASS) || (r_state == S_FAIL);
    assign w_tbl_wr        = i_tbl_we && w_idle_like && (32'(i_tbl_addr) < NUM_TEST);
    assign w_scan_prev_idx = r_scan - AWIDTH'(1);
    assign w_scan_cur      = r_tbl_num[r_scan];
    assign w_scan_prev     = r_tbl_num[w_scan_prev_idx];
    assign w_cur_num       = r_tbl_num[r_ptr];
    assign w_cur_ans       = r_tbl_ans[r_ptr];
    assign w_at            = (i_num_inst == w_cur_num);
    assign w_last          = (r_ptr == LAST_IDX);

    // Table write port: only while the checker is not busy, in-range indices only.
    always_ff @(posedge i_clk) begin
        if (w_tbl_wr) begin
            r_tbl_num[i_tbl_addr] <= i_tbl_num_inst;
            r_tbl_ans[i_tbl_addr] <= i_tbl_ans;
        end
    end

    // RUN-cycle verdict, in priority order: mismatch, skip, timeout, match, halt.
    always_comb begin
        w_run_code = FC_NONE;
        w_run_adv  = 1'b0;
        if (w_at && (i_output_port != w_cur_ans)) begin
            w_run_code = FC_MISMATCH;
        end else if (i_num_inst > w_cur_num) begin
            w_run_code = FC_SKIPPED;
        end else if (r_cycle_cnt == MAX_CYCLE) begin
            w_run_code = FC_TIMEOUT;
        end else if (w_at) begin
            w_run_adv = 1'b1;
        end else if (i_halt) begin
            w_run_code = FC_INCOMPLETE;
        end
    end

    // Checker state machine with all status outputs held in registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_scan      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= FC_NONE;
            r_fail_idx  <= '0;
            r_fail_got  <= '0;
            r_fail_exp  <= '0;
            r_pass_cnt  <= '0;
            r_cycle_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (i_start) begin
                        r_state     <= S_CHK_TBL;
                        r_ptr       <= '0;
                        r_scan      <= SCAN_FIRST;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_code <= FC_NONE;
                        r_fail_idx  <= '0;
                        r_fail_got  <= '0;
                        r_fail_exp  <= '0;
                        r_pass_cnt  <= '0;
                        r_cycle_cnt <= '0;
                    end
                end
                S_CHK_TBL: begin
                    if ((NUM_TEST > 1) && (w_scan_cur <= w_scan_prev)) begin
                        r_state     <= S_FAIL;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fail_code <= FC_ORDER;
                        r_fail_idx  <= r_scan;
                    end else if (r_scan >= LAST_IDX) begin
                        r_state <= S_RUN;
                    end else begin
                        r_scan <= r_scan + AWIDTH'(1);
                    end
                end
                S_RUN: begin
                    if (r_cycle_cnt != 32'hFFFF_FFFF) begin
                        r_cycle_cnt <= r_cycle_cnt + 32'd1;
                    end
                    if (w_run_code != FC_NONE) begin
                        r_state     <= S_FAIL;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fail_code <= w_run_code;
                        r_fail_idx  <= r_ptr;
                        r_fail_got  <= i_output_port;
                        r_fail_exp  <= w_cur_ans;
                    end else if (w_run_adv) begin
                        r_pass_cnt <= r_pass_cnt + (AWIDTH+1)'(1);
                        if (w_last) begin
                            r_state <= S_PASS;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + AWIDTH'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_fail_code = r_fail_code;
    assign o_fail_idx  = r_fail_idx;
    assign o_fail_got  = r_fail_got;
    assign o_fail_exp  = r_fail_exp;
    assign o_pass_cnt  = r_pass_cnt;
    assign o_cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_riscv_result_checker.sv
// Testbench for riscv_result_checker: directed scenarios followed by
// randomized tables/programs, each judged by an outcome model of the checker.
module tb_riscv_result_checker;

    localparam int          NT   = 3;
    localparam int          AW   = 5;
    localparam logic [31:0] MAXC = 32'd10;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   tnum_in;
    logic [31:0]   tans_in;
    logic          start;
    logic [31:0]   num;
    logic [31:0]   outp;
    logic          halt;
    logic          o_busy;
    logic          o_done;
    logic          o_pass;
    logic [2:0]    o_fail_code;
    logic [AW-1:0] o_fail_idx;
    logic [31:0]   o_fail_got;
    logic [31:0]   o_fail_exp;
    logic [AW:0]   o_pass_cnt;
    logic [31:0]   o_cycle_cnt;

    riscv_result_checker #(
        .NUM_TEST  (NT),
        .AWIDTH    (AW),
        .MAX_CYCLE (MAXC)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_tbl_we       (we),
        .i_tbl_addr     (addr),
        .i_tbl_num_inst (tnum_in),
        .i_tbl_ans      (tans_in),
        .i_start        (start),
        .i_num_inst     (num),
        .i_output_port  (outp),
        .i_halt         (halt),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_pass         (o_pass),
        .o_fail_code    (o_fail_code),
        .o_fail_idx     (o_fail_idx),
        .o_fail_got     (o_fail_got),
        .o_fail_exp     (o_fail_exp),
        .o_pass_cnt     (o_pass_cnt),
        .o_cycle_cnt    (o_cycle_cnt)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    string cur_test = "init";

    // Table contents and per-cycle core stimulus
    logic [31:0] t_num [NT];
    logic [31:0] t_ans [NT];
    logic [31:0] s_num [16];
    logic [31:0] s_out [16];
    bit          s_halt[16];

    // Predicted outcome
    int          m_code;
    int          m_idx;
    int          m_pcnt;
    int          m_cyc;
    int          m_term;
    bit          m_pass;
    logic [31:0] m_got;
    logic [31:0] m_exp;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s/%s got=0x%0h exp=0x%0h", cur_test, tag, got, exp);
        end
    endtask

    task automatic write_entry(input int idx, input logic [31:0] n, input logic [31:0] a);
        we = 1'b1; addr = AW'(idx); tnum_in = n; tans_in = a;
        tick;
        we = 1'b0;
    endtask

    task automatic load_table;
        for (int i = 0; i < NT; i++) write_entry(i, t_num[i], t_ans[i]);
    endtask

    task automatic set_pass_table;
        t_num[0] = 32'd1; t_ans[0] = 32'd0;
        t_num[1] = 32'd3; t_ans[1] = 32'd5;
        t_num[2] = 32'd4; t_ans[2] = 32'd0;
    endtask

    // Outcome of a program: first the table must be strictly increasing;
    // then the entries are consumed in order as the core's count reaches
    // them, and the first bad event ends the run.
    function automatic void model(input int len);
        int k;
        m_code = 0; m_idx = 0; m_pcnt = 0; m_cyc = 0; m_term = -1;
        m_pass = 1'b0; m_got = '0; m_exp = '0;
        for (int i = 1; i < NT; i++) begin
            if (t_num[i] <= t_num[i-1]) begin
                m_code = 4; m_idx = i;
                return;
            end
        end
        k = 0;
        for (int c = 0; c < len; c++) begin
            int code;
            code = 0;
            m_cyc = c + 1;
            if (s_num[c] == t_num[k] && s_out[c] != t_ans[k]) code = 1;
            else if (s_num[c] > t_num[k])                     code = 2;
            else if (c == int'(MAXC))                         code = 3;
            else if (s_num[c] == t_num[k]) begin
                k++;
                if (k == NT) begin
                    m_pass = 1'b1; m_term = c; m_pcnt = k;
                    return;
                end
            end else if (s_halt[c])                           code = 5;
            if (code != 0) begin
                m_code = code; m_idx = k; m_got = s_out[c]; m_exp = t_ans[k];
                m_term = c; m_pcnt = k;
                return;
            end
        end
        m_pcnt = k;
    endfunction

    task automatic check_idle_zero;
        chk("busy",  32'(o_busy), 32'd0);
        chk("done",  32'(o_done), 32'd0);
        chk("pass",  32'(o_pass), 32'd0);
        chk("code",  32'(o_fail_code), 32'd0);
        chk("idx",   32'(o_fail_idx), 32'd0);
        chk("got",   o_fail_got, 32'd0);
        chk("exp",   o_fail_exp, 32'd0);
        chk("pcnt",  32'(o_pass_cnt), 32'd0);
        chk("cycle", o_cycle_cnt, 32'd0);
    endtask

    // One START-to-verdict transaction
    task automatic run_prog(input int len, input bit wr_with_start, input bit wr_while_busy);
        bit exp_d;
        model(len);
        if (wr_with_start) begin
            we = 1'b1; addr = AW'(2); tnum_in = t_num[2]; tans_in = t_ans[2];
        end
        start = 1'b1;
        tick;
        start = 1'b0; we = 1'b0;
        chk("busy_after_start", 32'(o_busy), 32'd1);
        chk("done_after_start", 32'(o_done), 32'd0);
        for (int i = 1; i < NT; i++) begin
            if (wr_while_busy && i == 1) begin
                we = 1'b1; addr = AW'(1); tnum_in = 32'h77; tans_in = 32'h99;
            end
            tick;
            we = 1'b0;
            exp_d = (m_code == 4 && i == m_idx);
            chk("chk_done", 32'(o_done), 32'(exp_d));
            if (exp_d) break;
        end
        if (m_code != 4) begin
            for (int c = 0; c < len; c++) begin
                num = s_num[c]; outp = s_out[c]; halt = s_halt[c];
                tick;
                exp_d = (c == m_term);
                chk("run_done", 32'(o_done), 32'(exp_d));
                if (exp_d) break;
            end
        end
        halt = 1'b0;
        chk("busy_end",  32'(o_busy), 32'd0);
        chk("pass",      32'(o_pass), 32'(m_pass));
        chk("fail_code", 32'(o_fail_code), 32'(m_code));
        chk("fail_idx",  32'(o_fail_idx), 32'(m_idx));
        chk("pass_cnt",  32'(o_pass_cnt), 32'(m_pcnt));
        chk("cycle_cnt", o_cycle_cnt, 32'(m_cyc));
        if (m_code == 1 || m_code == 2) begin
            chk("fail_got", o_fail_got, m_got);
            chk("fail_exp", o_fail_exp, m_exp);
        end
        $display("[TB] %s: done=%0d pass=%0d code=%0d idx=%0d pass_cnt=%0d cycles=%0d",
                 cur_test, o_done, o_pass, o_fail_code, o_fail_idx, o_pass_cnt, o_cycle_cnt);
    endtask

    task automatic set_stim(input int c, input logic [31:0] n, input logic [31:0] o, input bit h);
        s_num[c] = n; s_out[c] = o; s_halt[c] = h;
    endtask

    initial begin
        int len;
        logic [31:0] cur;
        rst = 1'b1; we = 1'b0; addr = '0; tnum_in = '0; tans_in = '0;
        start = 1'b0; num = '0; outp = '0; halt = 1'b0;
        tick; tick;
        rst = 1'b0;
        cur_test = "reset";
        check_idle_zero;
        $display("[TB] reset: outputs checked");

        // Clean pass; match on last entry together with HALT; a write while busy is ignored
        cur_test = "pass";
        set_pass_table;
        load_table;
        set_stim(0, 0, 0, 0); set_stim(1, 1, 0, 0); set_stim(2, 2, 0, 0);
        set_stim(3, 3, 5, 0); set_stim(4, 4, 0, 1);
        run_prog(5, 0, 1);

        // Wrong value at count 3, with HALT on the same cycle
        cur_test = "mismatch";
        set_stim(3, 3, 32'h6, 1);
        run_prog(5, 0, 0);

        // Count jumps 2 -> 4
        cur_test = "skip";
        set_stim(0, 0, 0, 0); set_stim(1, 1, 0, 0); set_stim(2, 2, 0, 0);
        set_stim(3, 4, 0, 0); set_stim(4, 4, 0, 1);
        run_prog(5, 0, 0);

        // Non-increasing table
        cur_test = "order";
        t_num[0] = 32'd5; t_ans[0] = 32'd0;
        t_num[1] = 32'd5; t_ans[1] = 32'd1;
        t_num[2] = 32'd6; t_ans[2] = 32'd0;
        load_table;
        run_prog(5, 0, 0);

        // Count stuck at zero
        cur_test = "timeout";
        set_pass_table;
        load_table;
        for (int c = 0; c < 12; c++) set_stim(c, 0, 0, 0);
        run_prog(12, 0, 0);

        // HALT after only the first entry
        cur_test = "halt_early";
        set_stim(0, 0, 0, 0); set_stim(1, 1, 0, 1); set_stim(2, 1, 0, 1);
        run_prog(3, 0, 0);

        // Reset in the middle of RUN
        cur_test = "reset_mid_run";
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        num = 0; outp = 0; tick;
        num = 1; tick;
        rst = 1'b1; tick; rst = 1'b0;
        check_idle_zero;
        $display("[TB] reset_mid_run: outputs checked");

        // Reload with the last entry written on the START cycle
        cur_test = "rerun";
        set_pass_table;
        load_table;
        write_entry(2, 32'd2, 32'h55);
        set_stim(0, 0, 0, 0); set_stim(1, 1, 0, 0); set_stim(2, 2, 0, 0);
        set_stim(3, 3, 5, 0); set_stim(4, 4, 0, 0);
        run_prog(5, 1, 0);

        // Randomized tables and programs
        for (int r = 0; r < 40; r++) begin
            cur_test = $sformatf("rand%0d", r);
            t_num[0] = 32'($urandom_range(0, 2));
            t_ans[0] = 32'($urandom_range(0, 15));
            for (int i = 1; i < NT; i++) begin
                t_num[i] = t_num[i-1] + (($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 2)));
                t_ans[i] = 32'($urandom_range(0, 15));
            end
            load_table;
            len = int'($urandom_range(4, 14));
            cur = '0;
            for (int c = 0; c < len - 1; c++) begin
                int r8;
                s_num[c] = cur;
                s_out[c] = 32'($urandom_range(0, 15));
                for (int j = 0; j < NT; j++) begin
                    if (t_num[j] == cur) s_out[c] = ($urandom_range(0, 7) != 0) ? t_ans[j] : (t_ans[j] ^ 32'd1);
                end
                s_halt[c] = ($urandom_range(0, 15) == 0);
                r8 = int'($urandom_range(0, 7));
                cur = cur + ((r8 < 3) ? 32'd0 : ((r8 < 7) ? 32'd1 : 32'd2));
            end
            s_num[len-1]  = s_num[len-2];
            s_out[len-1]  = 32'($urandom_range(0, 15));
            s_halt[len-2] = 1'b1;
            s_halt[len-1] = 1'b1;
            run_prog(len, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
